// File: rtl/sd_cmd_sender.sv
// SD CMD-line frame sender: latches index/argument, has the shared CRC7 engine
// compute the frame CRC, then serializes the 48-bit frame MSB-first on tick.
module sd_cmd_sender #(
    parameter int CRC_TIMEOUT = 64,
    parameter int TICK_CNT_W  = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        cmd_ready,
    input  logic        tick,
    output logic        crc_load,
    output logic [39:0] crc_data,
    input  logic        crc_ready,
    input  logic [6:0]  crc,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic        done,
    output logic        crc_err
);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_CRC, SHIFT, DONE} state_t;

    localparam int                    TO_W       = $clog2(CRC_TIMEOUT + 1);
    // Giving up when the count would reach CRC_TIMEOUT-1 puts the crc_err
    // pulse exactly CRC_TIMEOUT cycles after the crc_load cycle.
    localparam logic [TO_W-1:0]       TO_LAST    = TO_W'(CRC_TIMEOUT - 2);
    localparam logic [TICK_CNT_W-1:0] LAST_SHIFT = TICK_CNT_W'(46);

    state_t                state;
    logic [TO_W-1:0]       to_cnt;
    logic [TICK_CNT_W-1:0] bit_cnt;
    logic [47:0]           shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            crc_load  <= 1'b0;
            crc_data  <= '0;
            cmd_out   <= 1'b1;
            cmd_oe    <= 1'b0;
            done      <= 1'b0;
            crc_err   <= 1'b0;
            to_cnt    <= '0;
            bit_cnt   <= '0;
        end else begin
            done     <= 1'b0;
            crc_err  <= 1'b0;
            crc_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        crc_data  <= {2'b01, cmd_index, cmd_arg};
                        cmd_ready <= 1'b0;
                        crc_load  <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    to_cnt <= '0;
                    state  <= WAIT_CRC;
                end
                WAIT_CRC: begin
                    if (crc_ready) begin
                        bit_cnt <= '0;
                        cmd_oe  <= 1'b1;
                        cmd_out <= shreg[47];
                        state   <= SHIFT;
                    end else if (to_cnt == TO_LAST) begin
                        crc_err   <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    // After the 47th shift the end bit is on the line; DONE holds it one tick.
                    if (tick) begin
                        cmd_out <= shreg[46];
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_SHIFT) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (tick) begin
                        cmd_oe    <= 1'b0;
                        cmd_out   <= 1'b1;
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Frame shift register is pure data; the state register alone gates its updates.
    always_ff @(posedge clk) begin
        case (state)
            IDLE:     if (cmd_valid) shreg <= {2'b01, cmd_index, cmd_arg, 8'h00};
            WAIT_CRC: if (crc_ready) shreg[7:0] <= {crc, 1'b1};
            SHIFT:    if (tick) shreg <= {shreg[46:0], 1'b0};
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_sd_cmd_sender.sv
// Bench for sd_cmd_sender: behavioural CRC7 engine stub, table of directed
// frames with hand-computed expected bits, plus multi-cycle corner sequences.
module tb_sd_cmd_sender;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic        cmd_ready;
    logic        tick = 1'b0;
    logic        crc_load;
    logic [39:0] crc_data;
    logic        crc_ready = 1'b0;
    logic [6:0]  crc = '0;
    logic        cmd_out;
    logic        cmd_oe;
    logic        done;
    logic        crc_err;

    always #5 clk = ~clk;

    sd_cmd_sender #(.CRC_TIMEOUT(64), .TICK_CNT_W(6)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_index(cmd_index),
        .cmd_arg(cmd_arg), .cmd_ready(cmd_ready), .tick(tick), .crc_load(crc_load),
        .crc_data(crc_data), .crc_ready(crc_ready), .crc(crc), .cmd_out(cmd_out),
        .cmd_oe(cmd_oe), .done(done), .crc_err(crc_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Tick generator: period 0 means no ticks at all.
    int tick_period = 0;
    int tcnt = 0;
    initial forever begin
        @(posedge clk);
        #1;
        tcnt++;
        if (tick_period == 0) tick = 1'b0;
        else                  tick = ((tcnt % tick_period) == 0);
    end

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // CRC7 engine stub: drops ready on load, answers after stub_delay cycles.
    int         stub_delay = 5;
    bit         stub_never = 1'b0;
    bit         stale_req = 1'b0;
    int         stub_cnt = 0;
    bit         armed = 1'b0;
    logic [6:0] crc_next = '0;
    always @(posedge clk) begin
        if (crc_load) begin
            crc_ready <= 1'b0;
            armed     <= 1'b1;
            stub_cnt  <= stub_delay;
            crc_next  <= crc7(crc_data);
        end else if (stale_req) begin
            crc_ready <= 1'b1;
            crc       <= 7'h7F;
            armed     <= 1'b0;
        end else if (armed && !stub_never) begin
            if (stub_cnt == 0) begin
                crc_ready <= 1'b1;
                crc       <= crc_next;
                armed     <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    // Line monitor: a bit is on the wire for the tick that ends its period.
    int   cyc = 0, oe_cycles = 0, done_cnt = 0, err_cnt = 0, load_cnt = 0;
    int   load_cyc = 0, err_cyc = 0;
    logic bits[$];
    always @(negedge clk) begin
        cyc++;
        if (cmd_oe) oe_cycles++;
        if (cmd_oe && tick) bits.push_back(cmd_out);
        if (done) done_cnt++;
        if (crc_err) begin err_cnt++; err_cyc = cyc; end
        if (crc_load) begin load_cnt++; load_cyc = cyc; end
    end

    int b_bits, b_oe, b_done, b_err, b_load;
    task automatic snap();
        b_bits = bits.size(); b_oe = oe_cycles; b_done = done_cnt;
        b_err = err_cnt; b_load = load_cnt;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired, got timeout, expected event", name);
    endtask

    task automatic get_frame(input int start, output logic [47:0] f);
        f = '0;
        for (int i = 0; i < 48; i++) begin
            f = {f[46:0], ((start + i) < bits.size()) ? bits[start + i] : 1'bx};
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
        if (!cmd_ready) timeout_fail("wait_ready");
    endtask

    task automatic send(input logic [5:0] idx, input logic [31:0] arg);
        wait_ready();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_index = idx; cmd_arg = arg;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 3000) begin @(negedge clk); n++; end
        if (done_cnt < target) timeout_fail("wait_done");
    endtask

    task automatic wait_bits(input int target);
        int n = 0;
        while (bits.size() < target && n < 3000) begin @(negedge clk); n++; end
        if (bits.size() < target) timeout_fail("wait_bits");
    endtask

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [47:0] frame;
        int          period;
        int          delay;
    } vec_t;
    vec_t        tv[6];
    logic [47:0] f;
    logic        held;
    int          changes;

    initial begin
        tv[0] = '{6'd0,  32'h0000_0000, 48'h4000_0000_0095, 4, 10};
        tv[1] = '{6'd8,  32'h0000_01AA, 48'h4800_0001_AA87, 4, 3};
        tv[2] = '{6'd17, 32'h0000_0000, 48'h5100_0000_0055, 4, 47};
        tv[3] = '{6'd0,  32'h0000_0000, 48'h4000_0000_0095, 1, 0};
        tv[4] = '{6'd8,  32'h0000_01AA, 48'h4800_0001_AA87, 1, 20};
        tv[5] = '{6'd17, 32'h0000_0000, 48'h5100_0000_0055, 3, 5};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst crc_load",  64'(crc_load),  64'd0);
        check("rst crc_data",  64'(crc_data),  64'd0);
        check("rst cmd_out",   64'(cmd_out),   64'd1);
        check("rst cmd_oe",    64'(cmd_oe),    64'd0);
        check("rst done",      64'(done),      64'd0);
        check("rst crc_err",   64'(crc_err),   64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            tick_period = tv[v].period;
            stub_delay  = tv[v].delay;
            snap();
            send(tv[v].idx, tv[v].arg);
            wait_done(b_done + 1);
            repeat (3) @(negedge clk);
            get_frame(b_bits, f);
            check($sformatf("v%0d frame", v),     64'(f), 64'(tv[v].frame));
            check($sformatf("v%0d bits", v),      64'(bits.size() - b_bits), 64'd48);
            check($sformatf("v%0d done", v),      64'(done_cnt - b_done), 64'd1);
            check($sformatf("v%0d crc_err", v),   64'(err_cnt - b_err), 64'd0);
            check($sformatf("v%0d crc_data", v),  64'(crc_data), 64'(tv[v].frame[47:8]));
            check($sformatf("v%0d ready", v),     64'(cmd_ready), 64'd1);
            check($sformatf("v%0d oe idle", v),   64'(cmd_oe), 64'd0);
            check($sformatf("v%0d out idle", v),  64'(cmd_out), 64'd1);
            if (tv[v].period == 1)
                check($sformatf("v%0d oe cycles", v), 64'(oe_cycles - b_oe), 64'd48);
        end

        // Back-to-back: request held while busy must not be taken until idle
        tick_period = 4; stub_delay = 6;
        snap();
        wait_ready();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_index = 6'd8; cmd_arg = 32'h0000_01AA;
        @(posedge clk); #1;
        cmd_index = 6'd17; cmd_arg = 32'h0;
        repeat (30) @(negedge clk);
        check("b2b busy ready", 64'(cmd_ready), 64'd0);
        check("b2b one load",   64'(load_cnt - b_load), 64'd1);
        begin
            int n = 0;
            while (load_cnt - b_load < 2 && n < 3000) begin @(negedge clk); n++; end
            if (load_cnt - b_load < 2) timeout_fail("b2b second load");
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done(b_done + 2);
        repeat (3) @(negedge clk);
        get_frame(b_bits, f);
        check("b2b frame1", 64'(f), 64'h4800_0001_AA87);
        get_frame(b_bits + 48, f);
        check("b2b frame2", 64'(f), 64'h5100_0000_0055);
        check("b2b loads",  64'(load_cnt - b_load), 64'd2);

        // CRC engine never answers
        stub_never = 1'b1;
        snap();
        send(6'd0, 32'h0);
        begin
            int n = 0;
            while (err_cnt == b_err && n < 500) begin @(negedge clk); n++; end
            if (err_cnt == b_err) timeout_fail("crc_err wait");
        end
        repeat (3) @(negedge clk);
        check("to latency",  64'(err_cyc - load_cyc), 64'd64);
        check("to pulses",   64'(err_cnt - b_err), 64'd1);
        check("to oe",       64'(oe_cycles - b_oe), 64'd0);
        check("to ready",    64'(cmd_ready), 64'd1);
        check("to no done",  64'(done_cnt - b_done), 64'd0);
        stub_never = 1'b0;

        // Stale crc_ready high before load must not be used
        @(posedge clk); #1; stale_req = 1'b1;
        @(posedge clk); #1; stale_req = 1'b0;
        stub_delay = 8; tick_period = 4;
        snap();
        send(6'd17, 32'h0);
        wait_done(b_done + 1);
        repeat (2) @(negedge clk);
        get_frame(b_bits, f);
        check("stale frame", 64'(f), 64'h5100_0000_0055);

        // Reset in the middle of a shift
        snap();
        send(6'd17, 32'h0);
        wait_bits(b_bits + 20);
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst oe",    64'(cmd_oe), 64'd0);
        check("midrst out",   64'(cmd_out), 64'd1);
        check("midrst ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1; reset = 1'b0;
        repeat (250) @(negedge clk);
        check("midrst no done", 64'(done_cnt - b_done), 64'd0);
        check("midrst no err",  64'(err_cnt - b_err), 64'd0);
        snap();
        send(6'd0, 32'h0);
        wait_done(b_done + 1);
        repeat (2) @(negedge clk);
        get_frame(b_bits, f);
        check("postrst frame", 64'(f), 64'h4000_0000_0095);

        // Reset and request in the same cycle: reset wins
        wait_ready();
        snap();
        @(posedge clk); #1;
        reset = 1'b1; cmd_valid = 1'b1; cmd_index = 6'd8; cmd_arg = 32'h1AA;
        @(posedge clk); #1;
        reset = 1'b0; cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rstvld no load", 64'(load_cnt - b_load), 64'd0);
        check("rstvld ready",   64'(cmd_ready), 64'd1);

        // Ticks stop mid-shift: line must freeze
        tick_period = 4;
        snap();
        send(6'd8, 32'h0000_01AA);
        wait_bits(b_bits + 10);
        tick_period = 0;
        repeat (2) @(negedge clk);
        held = cmd_out;
        b_oe = bits.size();
        changes = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_out !== held || cmd_oe !== 1'b1) changes++;
        end
        check("freeze changes", 64'(changes), 64'd0);
        check("freeze no bits", 64'(bits.size() - b_oe), 64'd0);
        tick_period = 4;
        wait_done(b_done + 1);
        repeat (2) @(negedge clk);
        get_frame(b_bits, f);
        check("freeze frame", 64'(f), 64'h4800_0001_AA87);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
